// File: rtl/if_id_queue_pkg.sv
// Shared fetch/decode constants: datapath width, NOP encoding and PC increment.
package if_id_queue_pkg;

  localparam int unsigned N         = 31;
  localparam int unsigned XLEN      = N + 1;
  localparam int unsigned NOP_INSTR = 0;
  localparam int unsigned PC_STEP   = 4;

endpackage : if_id_queue_pkg

// File: rtl/if_id_fifo_mem.sv
// Entry storage for the IF/ID queue: one synchronous write port and an
// asynchronous read port addressed by the read pointer. Contents are not reset.
module if_id_fifo_mem #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 1,
  parameter int unsigned DW    = 64
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_ptr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] rd_ptr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Capture the incoming entry at the write pointer.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule : if_id_fifo_mem

// File: rtl/if_id_queue.sv
// Fetch-to-decode buffer: FIFO of {pc, instr} with valid/ready handshakes,
// synchronous flush and a saturating fetch-stall counter.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned W       = XLEN,
  parameter int unsigned STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid,
  input  logic [W-1:0]       if_pc,
  input  logic [W-1:0]       if_instr,
  output logic               if_ready,
  output logic               id_valid,
  output logic [W-1:0]       id_pc,
  output logic [W-1:0]       id_pc_plus4,
  output logic [W-1:0]       id_instr,
  input  logic               id_ready,
  input  logic               flush,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW:0]    count;
  logic           push;
  logic           pop;
  logic [2*W-1:0] rd_entry;
  logic [W-1:0]   head_pc;
  logic [W-1:0]   head_instr;

  // Handshake derives only from registered occupancy: no decode-to-fetch path.
  assign if_ready = (count != FULL_COUNT);
  assign id_valid = (count != '0);
  assign push     = if_valid & if_ready & ~flush;
  assign pop      = id_valid & id_ready & ~flush;

  if_id_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (PW),
    .DW    (2 * W)
  ) u_mem (
    .clk    (clk),
    .we     (push),
    .wr_ptr (wr_ptr),
    .wdata  ({if_pc, if_instr}),
    .rd_ptr (rd_ptr),
    .rdata  (rd_entry)
  );

  assign head_pc    = rd_entry[2*W-1:W];
  assign head_instr = rd_entry[W-1:0];

  // Outputs read as zero/NOP while empty so stale storage never leaks out.
  always_comb begin
    id_pc       = '0;
    id_instr    = W'(NOP_INSTR);
    id_pc_plus4 = '0;
    if (id_valid) begin
      id_pc       = head_pc;
      id_instr    = head_instr;
      id_pc_plus4 = head_pc + W'(PC_STEP);
    end
  end

  // Pointer and occupancy update; flush overrides any push or pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Saturating count of cycles where fetch is held off; flush does not clear it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (if_valid && !if_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule : if_id_queue

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: directed scenarios plus random traffic.
module tb_if_id_queue;

  localparam int unsigned DEPTH   = 2;
  localparam int unsigned W       = 32;
  localparam int unsigned STALL_W = 16;

  typedef struct {
    logic [W-1:0] pc;
    logic [W-1:0] instr;
  } entry_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               if_valid = 1'b0;
  logic [W-1:0]       if_pc = '0;
  logic [W-1:0]       if_instr = '0;
  logic               if_ready;
  logic               id_valid;
  logic [W-1:0]       id_pc;
  logic [W-1:0]       id_pc_plus4;
  logic [W-1:0]       id_instr;
  logic               id_ready = 1'b0;
  logic               flush = 1'b0;
  logic [STALL_W-1:0] stall_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  entry_t      exp_q[$];
  int unsigned occ = 0;
  int unsigned stall_exp = 0;
  localparam int unsigned STALL_MAX = (1 << STALL_W) - 1;

  always #5 clk = ~clk;

  if_id_queue #(
    .DEPTH   (DEPTH),
    .W       (W),
    .STALL_W (STALL_W)
  ) dut (
    .clk         (clk),
    .rst         (rst_n),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .if_ready    (if_ready),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .id_instr    (id_instr),
    .id_ready    (id_ready),
    .flush       (flush),
    .stall_cnt   (stall_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy and accepted entries per the queue's rules.
  always @(posedge clk or negedge rst_n) begin
    bit can_push;
    bit do_pop;
    if (!rst_n) begin
      occ = 0;
      stall_exp = 0;
      exp_q.delete();
    end else begin
      can_push = (occ != DEPTH);
      do_pop   = (occ != 0) && id_ready;
      if (if_valid && !can_push && stall_exp != STALL_MAX) stall_exp++;
      if (flush) begin
        occ = 0;
        exp_q.delete();
      end else begin
        if (if_valid && can_push) begin
          exp_q.push_back('{pc: if_pc, instr: if_instr});
          occ++;
        end
        if (do_pop) occ--;
      end
    end
  end

  // Monitor: compare presented head and status every cycle, retire on handshake.
  always @(negedge clk) begin
    entry_t e;
    check("id_valid", 64'(id_valid), 64'(occ != 0));
    check("if_ready", 64'(if_ready), 64'(occ != DEPTH));
    check("stall_cnt", 64'(stall_cnt), 64'(stall_exp));
    if (!id_valid) begin
      check("empty_pc", 64'(id_pc), 64'd0);
      check("empty_instr", 64'(id_instr), 64'd0);
      check("empty_plus4", 64'(id_pc_plus4), 64'd0);
    end else if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL head_underflow: got id_valid=1 expected no entry at %0t", $time);
    end else begin
      e = exp_q[0];
      check("head_pc", 64'(id_pc), 64'(e.pc));
      check("head_instr", 64'(id_instr), 64'(e.instr));
      check("head_plus4", 64'(id_pc_plus4), 64'(W'(e.pc + 32'd4)));
      if (rst_n && id_ready && !flush) void'(exp_q.pop_front());
    end
  end

  task automatic step(input logic v, input logic [W-1:0] pc, input logic [W-1:0] ins,
                      input logic rdy, input logic fl);
    if_valid = v;
    if_pc    = pc;
    if_instr = ins;
    id_ready = rdy;
    flush    = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_id_valid", 64'(id_valid), 64'd0);
    check("rst_if_ready", 64'(if_ready), 64'd1);
    check("rst_stall", 64'(stall_cnt), 64'd0);
    rst_n = 1'b1;
    step(0, '0, '0, 0, 0);

    // Single entry with 1-cycle latency, then empty again
    step(1, 32'h0, 32'h2008_0005, 1, 0);
    check("t1_valid", 64'(id_valid), 64'd1);
    check("t1_plus4", 64'(id_pc_plus4), 64'h4);
    step(0, '0, '0, 1, 0);
    check("t1_empty", 64'(id_valid), 64'd0);

    // Fill while decode stalls, third fetch stalls
    step(1, 32'h0, 32'hA, 0, 0);
    step(1, 32'h4, 32'hB, 0, 0);
    check("t2_full", 64'(if_ready), 64'd0);
    step(1, 32'h8, 32'hC, 0, 0);
    check("t2_stall", 64'(stall_cnt), 64'd1);
    step(0, '0, '0, 1, 0);
    check("t2_ready_after_pop", 64'(if_ready), 64'd1);
    step(0, '0, '0, 1, 0);
    step(0, '0, '0, 1, 0);

    // Simultaneous push and pop at one entry
    step(1, 32'hC, 32'h11, 0, 0);
    step(1, 32'h10, 32'h22, 1, 0);
    check("t3_pc", 64'(id_pc), 64'h10);
    step(0, '0, '0, 1, 0);
    step(0, '0, '0, 1, 0);

    // Flush a full queue together with an incoming fetch
    step(1, 32'h20, 32'h33, 0, 0);
    step(1, 32'h24, 32'h44, 0, 0);
    step(1, 32'h28, 32'h55, 0, 1);
    check("t4_flushed", 64'(id_valid), 64'd0);
    check("t4_ready", 64'(if_ready), 64'd1);
    step(1, 32'h40, 32'h66, 0, 0);
    check("t4_pc", 64'(id_pc), 64'h40);
    step(0, '0, '0, 1, 0);
    step(0, '0, '0, 1, 0);

    // pc+4 wraps at the top of the address space
    step(1, 32'hFFFF_FFFC, 32'h77, 0, 0);
    check("t5_plus4", 64'(id_pc_plus4), 64'h0);
    step(0, '0, '0, 1, 0);
    step(0, '0, '0, 1, 0);

    // Random traffic with occasional flushes
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(3) != 0), W'($urandom) & ~W'(3), W'($urandom),
           ($urandom_range(2) != 0), ($urandom_range(15) == 0));
    end

    // Drain, then saturate the stall counter
    step(0, '0, '0, 1, 0);
    step(0, '0, '0, 1, 0);
    step(1, 32'h100, 32'h1, 0, 0);
    for (int i = 0; i < 70000; i++) step(1, 32'h104, 32'h2, 0, 0);
    check("t6_saturated", 64'(stall_cnt), 64'hFFFF);

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 64'(id_valid), 64'd0);
    check("t6_async_stall", 64'(stall_cnt), 64'd0);
    check("t6_async_ready", 64'(if_ready), 64'd1);
    step(0, '0, '0, 0, 0);
    rst_n = 1'b1;
    step(0, '0, '0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_if_id_queue
